// File: rtl/mmc3_scanline_irq_if.sv
// mmc3_scanline_irq_if: register-write strobes, raw PPU A12 and IRQ outputs
// between the mapper register decode and the scanline IRQ block.
interface mmc3_scanline_irq_if;
    logic       ppu_a12;
    logic [7:0] cpu_data;
    logic       wr_latch;
    logic       wr_reload;
    logic       wr_disable;
    logic       wr_enable;
    logic       irq;
    logic [7:0] irq_counter;

    modport master (
        output ppu_a12, cpu_data, wr_latch, wr_reload, wr_disable, wr_enable,
        input  irq, irq_counter
    );

    modport slave (
        input  ppu_a12, cpu_data, wr_latch, wr_reload, wr_disable, wr_enable,
        output irq, irq_counter
    );
endinterface

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3-class scanline IRQ generator clocked by CPU M2.
// Counts rising PPU A12 edges that follow a sufficiently long low time,
// reloads from a CPU-written latch and pulls irq low when the count hits 0.
// Optional macro MMC3_OLD_IRQ_EN selects Rev A / NEC zero detection: a
// reload from 0 only raises IRQ when a reload had been requested.
module mmc3_scanline_irq #(
    parameter int unsigned A12_FILTER  = 3,
    parameter int unsigned FILTER_BITS = 2
) (
    input  logic               m2,
    input  logic               reset,
    mmc3_scanline_irq_if.slave bus
);

    localparam logic [FILTER_BITS-1:0] FILTER_MAX = FILTER_BITS'(A12_FILTER);

    logic                   a12_s_q, a12_s_d;
    logic                   a12_prev_q, a12_prev_d;
    logic [FILTER_BITS-1:0] low_cnt_q, low_cnt_d;
    logic [7:0]             latch_q, latch_d;
    logic [7:0]             counter_q, counter_d;
    logic                   reload_flag_q, reload_flag_d;
    logic                   enabled_q, enabled_d;
    logic                   irq_q, irq_d;

    logic                   clk_evt;
    logic                   do_reload;
    logic                   zero_evt;

    // A12 synchroniser, edge history and saturating low-time filter
    always_comb begin
        a12_s_d    = bus.ppu_a12;
        a12_prev_d = a12_s_q;
        low_cnt_d  = '0;
        if (!a12_s_q) begin
            low_cnt_d = (low_cnt_q == FILTER_MAX) ? low_cnt_q
                                                  : low_cnt_q + FILTER_BITS'(1);
        end
        clk_evt = a12_s_q && !a12_prev_q && (low_cnt_q == FILTER_MAX);
    end

    // Register writes, counter reload/decrement and IRQ set/acknowledge.
    // A latch write coincident with a reload feeds the new value straight
    // through, and a pending reload request counts as a reload this cycle.
    always_comb begin
        latch_d       = bus.wr_latch ? bus.cpu_data : latch_q;
        counter_d     = counter_q;
        reload_flag_d = reload_flag_q;
        do_reload     = (counter_q == '0) || reload_flag_q || bus.wr_reload;

        if (clk_evt) begin
            counter_d     = do_reload ? latch_d : counter_q - 8'd1;
            reload_flag_d = 1'b0;
        end else if (bus.wr_reload) begin
            counter_d     = '0;
            reload_flag_d = 1'b1;
        end

`ifdef MMC3_OLD_IRQ_EN
        zero_evt = clk_evt && (counter_d == '0) &&
                   (!do_reload || reload_flag_q || bus.wr_reload);
`else
        zero_evt = clk_evt && (counter_d == '0);
`endif

        enabled_d = enabled_q;
        if (bus.wr_enable)
            enabled_d = 1'b1;
        if (bus.wr_disable)
            enabled_d = 1'b0;

        irq_d = irq_q;
        if (zero_evt && enabled_d)
            irq_d = 1'b0;
        if (bus.wr_disable)
            irq_d = 1'b1;
    end

    // State registers; a12 history resets high so release cannot fake an edge
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            a12_s_q       <= 1'b1;
            a12_prev_q    <= 1'b1;
            low_cnt_q     <= '0;
            latch_q       <= '0;
            counter_q     <= '0;
            reload_flag_q <= 1'b0;
            enabled_q     <= 1'b0;
            irq_q         <= 1'b1;
        end else begin
            a12_s_q       <= a12_s_d;
            a12_prev_q    <= a12_prev_d;
            low_cnt_q     <= low_cnt_d;
            latch_q       <= latch_d;
            counter_q     <= counter_d;
            reload_flag_q <= reload_flag_d;
            enabled_q     <= enabled_d;
            irq_q         <= irq_d;
        end
    end

    assign bus.irq         = irq_q;
    assign bus.irq_counter = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: directed and randomised checks of the scanline IRQ
// block against a history-based behavioural model.
module tb_mmc3_scanline_irq;

    localparam int FILTER = 3;

    logic m2;
    logic reset;

    mmc3_scanline_irq_if bus ();

    mmc3_scanline_irq #(
        .A12_FILTER (FILTER),
        .FILTER_BITS(2)
    ) dut (
        .m2   (m2),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    int checks;
    int errors;

    // Behavioural model: sampled A12 history plus the architectural registers
    bit       hist[$];
    bit [7:0] m_latch;
    bit [7:0] m_counter;
    bit       m_rflag;
    bit       m_en;
    bit       m_irq;

    task automatic model_reset();
        hist      = {1'b1};
        m_latch   = 8'd0;
        m_counter = 8'd0;
        m_rflag   = 1'b0;
        m_en      = 1'b0;
        m_irq     = 1'b1;
    endtask

    // A counted edge: newest sample high, previous low, and at least FILTER
    // consecutive low samples ending at the previous one.
    function automatic bit model_evt();
        int run;
        if (hist.size() < 2) return 1'b0;
        if (hist[hist.size()-1] != 1'b1 || hist[hist.size()-2] != 1'b0) return 1'b0;
        run = 0;
        for (int i = hist.size() - 2; i >= 0; i--) begin
            if (hist[i] != 1'b0) break;
            run++;
        end
        return run >= FILTER;
    endfunction

    task automatic model_step();
        bit       evt, reloaded, flagged, zero;
        bit [7:0] nl, nc;
        bit       nf, ne;
        evt      = model_evt();
        nl       = bus.wr_latch ? bus.cpu_data : m_latch;
        nc       = m_counter;
        nf       = m_rflag;
        reloaded = 1'b0;
        flagged  = m_rflag || bus.wr_reload;
        if (evt) begin
            if (m_counter == 0 || flagged) begin
                nc = nl;
                reloaded = 1'b1;
            end else begin
                nc = m_counter - 1;
            end
            nf = 1'b0;
        end else if (bus.wr_reload) begin
            nc = 0;
            nf = 1'b1;
        end
`ifdef MMC3_OLD_IRQ_EN
        zero = evt && nc == 0 && (!reloaded || flagged);
`else
        zero = evt && nc == 0;
`endif
        ne = bus.wr_disable ? 1'b0 : (bus.wr_enable ? 1'b1 : m_en);
        if (zero && ne) m_irq = 1'b0;
        if (bus.wr_disable) m_irq = 1'b1;
        m_latch   = nl;
        m_counter = nc;
        m_rflag   = nf;
        m_en      = ne;
        hist.push_back(bus.ppu_a12);
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    // One m2 cycle: model follows the edge, strobes are one-shot
    task automatic cycle();
        if (reset) model_reset();
        else model_step();
        @(posedge m2);
        #1;
        bus.wr_latch   = 1'b0;
        bus.wr_reload  = 1'b0;
        bus.wr_disable = 1'b0;
        bus.wr_enable  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic write_latch(input bit [7:0] d);
        bus.cpu_data = d;
        bus.wr_latch = 1'b1;
        cycle();
    endtask

    task automatic strobe_reload();
        bus.wr_reload = 1'b1;
        cycle();
    endtask

    task automatic strobe_enable();
        bus.wr_enable = 1'b1;
        cycle();
    endtask

    task automatic strobe_disable();
        bus.wr_disable = 1'b1;
        cycle();
    endtask

    task automatic pulse(input int low_len, input int high_len);
        bus.ppu_a12 = 1'b0;
        repeat (low_len) cycle();
        bus.ppu_a12 = 1'b1;
        repeat (high_len) cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_counter !== 8'd0) begin
            errors++;
            $display("FAIL reset_state irq=%b cnt=%0d required irq=1 cnt=0", bus.irq, bus.irq_counter);
        end
        write_latch(8'd0);
        strobe_reload();
        strobe_enable();
        pulse(8, 4);
        write_latch(8'd5);
        pulse(8, 4);
        checks++;
        if (bus.irq !== 1'b0 || bus.irq_counter !== 8'd5) begin
            errors++;
            $display("FAIL reset_setup irq=%b cnt=%0d required irq=0 cnt=5", bus.irq, bus.irq_counter);
        end
        bus.ppu_a12 = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_counter !== 8'd0) begin
            errors++;
            $display("FAIL reset_async irq=%b cnt=%0d required irq=1 cnt=0", bus.irq, bus.irq_counter);
        end
        repeat (2) cycle();
        reset = 1'b0;
        write_latch(8'd7);
        bus.ppu_a12 = 1'b1;
        repeat (4) cycle();
        checks++;
        if (bus.irq_counter !== 8'd0 || bus.irq_counter !== m_counter) begin
            errors++;
            $display("FAIL reset_no_edge cnt=%0d required 0 (model %0d)", bus.irq_counter, m_counter);
        end
    endtask

    task automatic test_basic_count();
        bit [7:0] exp_seq[3];
        exp_seq = '{8'd3, 8'd2, 8'd1};
        do_reset();
        write_latch(8'd3);
        strobe_reload();
        strobe_enable();
        for (int i = 0; i < 3; i++) begin
            pulse(8, 4);
            checks++;
            if (bus.irq_counter !== exp_seq[i] || bus.irq_counter !== m_counter || bus.irq !== 1'b1) begin
                errors++;
                $display("FAIL basic_count[%0d] cnt=%0d irq=%b required cnt=%0d irq=1", i, bus.irq_counter, bus.irq, exp_seq[i]);
            end
        end
        bus.ppu_a12 = 1'b0;
        repeat (8) cycle();
        bus.ppu_a12 = 1'b1;
        cycle();
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL basic_irq_early irq=%b required 1", bus.irq);
        end
        cycle();
        checks++;
        if (bus.irq !== 1'b0 || bus.irq_counter !== 8'd0 || bus.irq !== m_irq) begin
            errors++;
            $display("FAIL basic_irq_low irq=%b cnt=%0d required irq=0 cnt=0", bus.irq, bus.irq_counter);
        end
        repeat (3) cycle();
        strobe_disable();
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_filter();
        do_reset();
        write_latch(8'd9);
        strobe_reload();
        pulse(8, 4);
        checks++;
        if (bus.irq_counter !== 8'd9) begin
            errors++;
            $display("FAIL filter_load cnt=%0d required 9", bus.irq_counter);
        end
        pulse(2, 4);
        checks++;
        if (bus.irq_counter !== 8'd9 || bus.irq_counter !== m_counter) begin
            errors++;
            $display("FAIL filter_short cnt=%0d required 9", bus.irq_counter);
        end
        pulse(3, 4);
        checks++;
        if (bus.irq_counter !== 8'd8 || bus.irq_counter !== m_counter) begin
            errors++;
            $display("FAIL filter_exact cnt=%0d required 8", bus.irq_counter);
        end
    endtask

    task automatic test_simul_latch();
        do_reset();
        write_latch(8'd0);
        strobe_reload();
        pulse(8, 4);
        bus.ppu_a12 = 1'b0;
        repeat (8) cycle();
        bus.ppu_a12 = 1'b1;
        cycle();
        write_latch(8'h10);
        checks++;
        if (bus.irq_counter !== 8'h10 || bus.irq_counter !== m_counter) begin
            errors++;
            $display("FAIL simul_latch cnt=%0h required 10", bus.irq_counter);
        end
    endtask

    task automatic test_latch_zero();
        bit exp_first;
`ifdef MMC3_OLD_IRQ_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        // no reload request: only the new behaviour fires from counter 0
        do_reset();
        strobe_enable();
        pulse(8, 4);
        checks++;
        if (bus.irq !== exp_first || bus.irq !== m_irq) begin
            errors++;
            $display("FAIL latch_zero_noflag irq=%b required %b", bus.irq, exp_first);
        end
        // with a reload request both behaviours fire on the first pulse
        do_reset();
        strobe_reload();
        strobe_enable();
        for (int i = 0; i < 3; i++) begin
            pulse(8, 4);
            checks++;
            if (bus.irq !== 1'b0 || bus.irq_counter !== 8'd0) begin
                errors++;
                $display("FAIL latch_zero_flag[%0d] irq=%b cnt=%0d required irq=0 cnt=0", i, bus.irq, bus.irq_counter);
            end
            strobe_disable();
            strobe_enable();
            checks++;
            if (bus.irq !== 1'b1) begin
                errors++;
                $display("FAIL latch_zero_ack[%0d] irq=%b required 1", i, bus.irq);
            end
            if (i == 0) strobe_reload();
        end
    endtask

    task automatic test_disable_precedence();
        do_reset();
        write_latch(8'd1);
        strobe_reload();
        strobe_enable();
        pulse(8, 4);
        bus.ppu_a12 = 1'b0;
        repeat (8) cycle();
        bus.ppu_a12 = 1'b1;
        cycle();
        strobe_disable();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_counter !== 8'd0) begin
            errors++;
            $display("FAIL disable_wins irq=%b cnt=%0d required irq=1 cnt=0", bus.irq, bus.irq_counter);
        end
        strobe_enable();
        cycle();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq !== m_irq) begin
            errors++;
            $display("FAIL enable_alone irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_random();
        int run_left;
        int bad;
        do_reset();
        run_left = 0;
        bad = 0;
        for (int n = 0; n < 2000; n++) begin
            if (run_left == 0) begin
                bus.ppu_a12 = ~bus.ppu_a12;
                run_left = $urandom_range(1, 6);
            end
            run_left--;
            bus.cpu_data   = 8'($urandom_range(0, 4));
            bus.wr_latch   = ($urandom_range(0, 15) == 0);
            bus.wr_reload  = ($urandom_range(0, 23) == 0);
            bus.wr_disable = ($urandom_range(0, 31) == 0);
            bus.wr_enable  = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if (bus.irq_counter !== m_counter || bus.irq !== m_irq) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d] cnt=%0d irq=%b required cnt=%0d irq=%b", n, bus.irq_counter, bus.irq, m_counter, m_irq);
                bad++;
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.ppu_a12    = 1'b0;
        bus.cpu_data   = 8'd0;
        bus.wr_latch   = 1'b0;
        bus.wr_reload  = 1'b0;
        bus.wr_disable = 1'b0;
        bus.wr_enable  = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic_count();
        test_filter();
        test_simul_latch();
        test_latch_zero();
        test_disable_precedence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
